// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the word-level "1010" scan controller
// and its bit-serial Mealy detector.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    RESP
  } ctrl_state_e;

  typedef enum logic [1:0] {
    S0,
    S1,
    S10,
    S101
  } det_state_e;

  localparam logic [3:0] PATTERN = 4'b1010;

endpackage : seq_scan_pkg

// File: rtl/pattern_det_1010.sv
// Bit-serial Mealy detector for the pattern held in seq_scan_pkg::PATTERN.
// Advances only on step; clr forces S0 and takes priority over step.
module pattern_det_1010
  import seq_scan_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic step,
  input  logic ovl,
  input  logic x,
  output logic match
);

  det_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    match   = 1'b0;
    if (clr) begin
      state_d = S0;
    end else if (step) begin
      case (state_q)
        S0:   state_d = (x == PATTERN[3]) ? S1 : S0;
        S1:   state_d = (x == PATTERN[2]) ? S10 : S1;
        S10:  state_d = (x == PATTERN[1]) ? S101 : S0;
        S101: begin
          if (x == PATTERN[0]) begin
            match   = 1'b1;
            // Overlap keeps the trailing "10" as the start of the next match
            state_d = ovl ? S10 : S0;
          end else begin
            state_d = S1;
          end
        end
        default: state_d = S0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

endmodule : pattern_det_1010

// File: rtl/seq_scan_ctrl.sv
// Accepts a W-bit word, shifts it MSB-first through the 1010 detector and
// returns a saturating match count over a valid/ready result handshake.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          ovl,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_count,
  output logic          out_hit,
  output logic          busy
);

  localparam int BW = $clog2(W);
  localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};
  localparam logic [BW-1:0] LAST_BIT  = BW'(W - 1);

  ctrl_state_e   state_q, state_d;
  logic [W-1:0]  shreg_q, shreg_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovl_q, ovl_d;
  logic          det_clr, det_step, det_match;

  pattern_det_1010 u_det (
    .clk   (clk),
    .rst   (rst),
    .clr   (det_clr),
    .step  (det_step),
    .ovl   (ovl_q),
    .x     (shreg_q[W-1]),
    .match (det_match)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    count_d  = count_q;
    ovl_d    = ovl_q;
    det_clr  = 1'b0;
    det_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d  = in_data;
          ovl_d    = ovl;
          bitcnt_d = '0;
          count_d  = '0;
          det_clr  = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        det_step = 1'b1;
        shreg_d  = {shreg_q[W-2:0], 1'b0};
        bitcnt_d = bitcnt_q + 1'b1;
        if (bitcnt_q == LAST_BIT) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Saturate rather than wrap so a full count still reads as "many"
    if (det_step && det_match && (count_q != COUNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      count_q  <= '0;
      ovl_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      count_q  <= count_d;
      ovl_q    <= ovl_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign out_count = count_q;
  assign out_hit   = |count_q;

endmodule : seq_scan_ctrl

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Word-level controller that sequences a bit-serial "1010" Mealy pattern detector. It accepts a W-bit word over a valid/ready handshake and shifts the word MSB-first through the detector, one bit per clock. It counts detected patterns and returns the count over a second valid/ready handshake. It sits between a parallel producer (bus/register interface) and the serial detection datapath, and owns detector clearing, overlap-mode configuration and result hand-off.

## Interface
- W, 16, word width in bits; legal range W ≥ 4
- CW, 4, width of the match counter; the counter saturates at 2^CW−1
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- in_valid  input  1  word offered
- in_ready  output  1  controller can accept a word (high only in IDLE)
- in_data  input  W  word to scan, MSB scanned first
- ovl  input  1  overlap mode, sampled with in_data on accept; 1 = overlapping matches, 0 = non-overlapping
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_count  output  CW  number of matches in the word, saturating
- out_hit  output  1  out_count != 0
- busy  output  1  high in SHIFT or RESP

## Operation
- Controller FSM states:
  - IDLE: in_ready=1. When in_valid, load the shift register with in_data, latch ovl, clear bitcnt and count, synchronously clear the detector to S0, then go to SHIFT.
  - SHIFT: each cycle, drive shreg[W−1] to the detector with step=1, shift shreg left, and increment bitcnt. When bitcnt==W−1, go to RESP.
  - RESP: out_valid=1. When out_ready, go to IDLE.
- Detector states (sub-module), stepping only when step=1:
  - S0: a 1 goes to S1; a 0 stays in S0.
  - S1: a 1 stays in S1; a 0 goes to S10.
  - S10: a 1 goes to S101; a 0 goes to S0.
  - S101: a 1 goes to S1. A 0 asserts match (combinational Mealy output, same cycle) and goes to S10 if ovl=1, or to S0 if ovl=0.
- Counting: count increments on the edge where step and match are both high. At 2^CW−1 the count holds; it never wraps.
- Patterns never span words, because the detector is cleared on every accept.
- in_valid outside IDLE is ignored; in_data is not sampled.
- out_count and out_hit stay stable while out_valid=1 and out_ready=0.
- Reset (any state, including mid-SHIFT): returns to IDLE with the detector in S0 and count=0. The partial word is discarded and no result is produced for it.
- Reset values: in_ready=1, out_valid=0, out_count=0, out_hit=0, busy=0.

## Timing
- Accept occurs on the edge where in_valid and in_ready are both high; call it edge E0.
- Bits are consumed on edges E1..EW: bit W−1 on E1, bit 0 on EW.
- out_valid rises after EW, i.e. exactly W edges after accept.
- With out_ready tied high, RESP lasts 1 cycle. in_ready returns after edge EW+1, so the minimum word period is W+2 cycles.
- No combinational path exists from in_valid to in_ready, or from out_ready to out_valid.
- busy rises after E0 and falls on the edge that leaves RESP.

## Structure
- Package seq_scan_pkg holds:
  - the controller state enum (IDLE, SHIFT, RESP);
  - the detector state enum (S0, S1, S10, S101);
  - the pattern constant 4'b1010.
- Sub-module pattern_det_1010 has ports clk, rst, clr, step, ovl, x, match. It holds only the detector state register plus the combinational next-state and match logic.
- seq_scan_ctrl holds the controller FSM, the shift register, the bit counter (width clog2(W)) and the saturating counter.

## Test plan
- in_data=16'hA000, ovl=0 → out_count=1 and out_hit=1; out_valid rises exactly 16 edges after accept.
- in_data=16'hAAAA → out_count=4 with ovl=0, and out_count=7 with ovl=1.
- in_data=16'h5555 → out_count=3 with ovl=0, and 6 with ovl=1. Then send 16'h0001 followed by 16'h4000 → both words give out_count=0 (no cross-word match).
- Backpressure test:
  - hold out_ready=0 for 5 cycles after out_valid;
  - required: out_valid and out_count are held and in_ready=0;
  - a second word offered during SHIFT is not accepted; it is accepted only after the result handshake.
- Assert rst low after 8 bits of 16'hAAAA → all outputs take their reset values immediately and no result is produced. After release, 16'h000A with ovl=0 → out_count=1.
- Saturation: with CW=2 override, in_data=16'hAAAA and ovl=1 → out_count=3 (held, not wrapped); out_hit=1.
